// File: rtl/reg_file_shadow.sv
// 2-read/1-write register file with write-through bypass, optional hardwired r0,
// and a shadow bank filled/drained one register per cycle by a save/restore engine.
module reg_file_shadow #(
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 3,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Wen,
  input  logic [AW-1:0] Wd,
  input  logic [DW-1:0] Wdat,
  input  logic [AW-1:0] Ra,
  input  logic [AW-1:0] Rb,
  output logic [DW-1:0] RdatA,
  output logic [DW-1:0] RdatB,
  input  logic          SaveReq,
  input  logic          RestReq,
  output logic          Busy,
  output logic          Done,
  output logic          WrDrop
);

  localparam int unsigned Depth = 1 << AW;

  typedef enum logic [1:0] {StIdle, StSave, StRest} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wr_drop_q, wr_drop_d;
  logic [DW-1:0] core_q   [Depth];
  logic [DW-1:0] core_d   [Depth];
  logic [DW-1:0] shadow_q [Depth];
  logic [DW-1:0] shadow_d [Depth];
  logic          wr_ok;
  logic          wr_en;

  // Port writes are only accepted while the engine is idle, so they never race a restore.
  assign wr_ok = Wen && !busy_q;
  assign wr_en = wr_ok && !(ZERO_R0 && (Wd == '0));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    wr_drop_d = Wen && busy_q;
    core_d    = core_q;
    shadow_d  = shadow_q;

    if (wr_en) begin
      core_d[Wd] = Wdat;
    end

    unique case (state_q)
      StIdle: begin
        if (SaveReq) begin
          state_d = StSave;
        end else if (RestReq) begin
          state_d = StRest;
        end
      end
      StSave, StRest: begin
        if (state_q == StSave) begin
          shadow_d[idx_q] = core_q[idx_q];
        end else if (!(ZERO_R0 && (idx_q == '0))) begin
          core_d[idx_q] = shadow_q[idx_q];
        end
        idx_d = idx_q + AW'(1);
        if (&idx_q) begin
          state_d = StIdle;
          idx_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_drop_q <= 1'b0;
      for (int unsigned i = 0; i < Depth; i++) begin
        core_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_drop_q <= wr_drop_d;
      core_q    <= core_d;
      shadow_q  <= shadow_d;
    end
  end

  always_comb begin
    RdatA = core_q[Ra];
    if (wr_ok && (Wd == Ra)) begin
      RdatA = Wdat;
    end
    if (ZERO_R0 && (Ra == '0)) begin
      RdatA = '0;
    end
  end

  always_comb begin
    RdatB = core_q[Rb];
    if (wr_ok && (Wd == Rb)) begin
      RdatB = Wdat;
    end
    if (ZERO_R0 && (Rb == '0)) begin
      RdatB = '0;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign WrDrop = wr_drop_q;

endmodule
